// File: rtl/vector_stream_regfile.sv
// Vector register file loaded by a valid/ready stream or by random-access writes; optional rotate via VEC_REGFILE_ROTATE_EN.
// Latency: every update lands on the next rising edge; data_flat is read straight from the entry flops.
// Backpressure: s_ready drops while full or while clr/w_en (and rot_en when rotate is built) claim the cycle.
module vector_stream_regfile #(
    parameter int  DATA_W = 34,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    input  logic                    w_en,
    input  logic [ADDR_W-1:0]       w_addr,
    input  logic [DATA_W-1:0]       w_data,
    input  logic                    rot_en,
    output logic [ADDR_W-1:0]       wr_ptr,
    output logic                    full,
    output logic [DEPTH*DATA_W-1:0] data_flat
);

    logic [DATA_W-1:0] ent_q [DEPTH];
    logic [DATA_W-1:0] ent_d [DEPTH];
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              accept;

    // Count saturates at exactly DEPTH, so its MSB is the full flag and the low bits wrap wr_ptr to 0.
    assign full   = cnt_q[ADDR_W];
    assign wr_ptr = cnt_q[ADDR_W-1:0];

`ifdef VEC_REGFILE_ROTATE_EN
    assign s_ready = !full && !clr && !w_en && !rot_en;
`else
    logic unused_rot_en;
    assign unused_rot_en = rot_en;
    assign s_ready       = !full && !clr && !w_en;
`endif

    assign accept = s_valid && s_ready;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (clr) begin
            cnt_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end else if (w_en) begin
            ent_d[w_addr] = w_data;
        end else if (accept) begin
            ent_d[wr_ptr] = s_data;
            cnt_d         = cnt_q + 1'b1;
        end
`ifdef VEC_REGFILE_ROTATE_EN
        else if (rot_en) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[DEPTH-1] = ent_q[0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign data_flat[g*DATA_W +: DATA_W] = ent_q[g];
    end

endmodule

// File: doc/vector_stream_regfile.md
VECTOR_STREAM_REGFILE -- requirements
Module: vector_stream_regfile

Interface
REQ-001 Parameter: DATA_W, 34, width of one vector element in bits.
REQ-002 Parameter: DEPTH, 8, number of entries; a power of two, at least 2.
REQ-003 Parameter: ADDR_W, $clog2(DEPTH), entry address width; derived, never overridden.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: clr  input  1  synchronous clear of all entries and load counter.
REQ-007 Port: s_valid  input  1  stream-load beat valid.
REQ-008 Port: s_data  input  DATA_W  stream-load beat data.
REQ-009 Port: s_ready  output  1  stream-load beat accepted when s_valid && s_ready.
REQ-010 Port: w_en  input  1  random-access write strobe.
REQ-011 Port: w_addr  input  ADDR_W  random-access write address.
REQ-012 Port: w_data  input  DATA_W  random-access write data.
REQ-013 Port: rot_en  input  1  rotate-all-entries request.
REQ-014 Port: wr_ptr  output  ADDR_W  next stream-load entry index.
REQ-015 Port: full  output  1  all DEPTH entries stream-loaded since last clear/reset.
REQ-016 Port: data_flat  output  DEPTH*DATA_W  entry i on bits [i*DATA_W +: DATA_W], registered, no read latency.

Function
REQ-017 Per-cycle priority SHALL be: clr, then w_en, then stream accept, then rotate; at most one operation updates the entries per cycle.
REQ-018 clr SHALL zero all entries, load count and full on the next edge.
REQ-019 w_en with clr low SHALL write w_data to entry w_addr; load count is unchanged.
REQ-020 s_ready SHALL equal !full && !clr && !w_en (combinational).
REQ-021 On accept, s_data SHALL be written to entry wr_ptr and the load count (ADDR_W+1 bits) incremented by 1.
REQ-022 wr_ptr SHALL equal load count modulo DEPTH; after the DEPTH-th beat wr_ptr wraps to 0 and full asserts in the same edge.
REQ-023 While full, s_ready SHALL be 0 and beats are neither accepted nor written, until clr or reset.
REQ-024 s_valid low or s_ready low SHALL leave entries and count unchanged (backpressure holds no internal state).
REQ-025 Rotate (when enabled, see REQ-029) with no higher-priority operation SHALL set entry i to old entry i+1 for i<DEPTH-1 and entry DEPTH-1 to old entry 0, in one cycle; count, wr_ptr, full unchanged.
REQ-026 w_addr out of range is impossible by construction (ADDR_W exact); no error flag.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force all entries to 0, load count to 0, wr_ptr to 0, full to 0; s_ready reads 1 when w_en and clr are low.
REQ-028 Reset asserted mid-load SHALL discard the partial load; first beat after release writes entry 0.

Configuration
REQ-029 Macro VEC_REGFILE_ROTATE_EN: defined -> rotate per REQ-025 and s_ready additionally requires !rot_en; undefined -> rot_en ignored, no rotate logic, s_ready per REQ-020.

Verification
REQ-030 Reset, then 8 beats 0x1..0x8 with s_valid held -> entries 0..7 = 0x1..0x8, full=1 after 8th edge, wr_ptr=0, s_ready=0.
REQ-031 9th beat 0x9 presented while full -> no entry changes, s_ready=0; clr pulse -> all entries 0, full=0, s_ready=1.
REQ-032 After 3 beats, w_en=1 w_addr=5 w_data=0x3FFFFFFFF with s_valid=1 -> entry 5 written, s_ready=0 that cycle, wr_ptr stays 3.
REQ-033 With VEC_REGFILE_ROTATE_EN, entries 0..7 = 0x1..0x8, rot_en one cycle -> entries 0..7 = 0x2..0x8,0x1; without macro -> unchanged.
REQ-034 rst_n pulsed low between clock edges after 4 beats -> outputs zero before next edge; next beat lands at entry 0, wr_ptr=1.
